// File: rtl/reg8_shift8_unit_pkg.sv
// rtl/reg8_shift8_unit_pkg.sv - shared constants for the register/shift storage block
//
// Purpose: holds the default data width used by reg8_shift8_unit and its bench.
// Contents: WIDTH_DEFAULT only; the block needs no typedefs.
package reg8_shift8_unit_pkg;

  // Default width of both the parallel register and the shift register.
  localparam int WIDTH_DEFAULT = 8;

endpackage : reg8_shift8_unit_pkg

// File: rtl/reg8_shift8_unit_dff_bit.sv
// rtl/reg8_shift8_unit_dff_bit.sv - 1-bit D flip-flop cell with synchronous active-low clear
//
// Purpose: single storage cell; the parallel register is built from WIDTH of these.
// Ports:
//   clk - clock, captures on rising edge
//   rst - synchronous reset, active-low; clears q to 0 on a rising edge
//   d   - data bit captured when rst is high
//   q   - registered data bit
module dff_bit (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

endmodule : dff_bit

// File: rtl/reg8_shift8_unit.sv
// rtl/reg8_shift8_unit.sv - parallel-load register plus serial-in/parallel-out shift register
//
// Purpose: two independent WIDTH-bit registers on one clock and one reset.
//   The parallel register is built from per-bit dff_bit cells; the shift
//   register is behavioural and shifts left with new bits entering at the LSB.
// Ports:
//   clk       - clock, all state updates on rising edge
//   rst       - synchronous reset, active-low; clears both registers
//   in        - parallel data, captured into out one edge later
//   shift_in  - serial data bit, shifted into shift_out[0]
//   out       - parallel register contents
//   shift_out - shift register contents
module reg8_shift8_unit
  import reg8_shift8_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             shift_in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] shift_out
);

  // Parallel register: one cell per bit, each wired straight to clk and rst
  // so its behaviour matches a plain WIDTH-bit register bit for bit.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_par_bit
      dff_bit u_bit (
        .clk (clk),
        .rst (rst),
        .d   (in[gi]),
        .q   (out[gi])
      );
    end
  endgenerate

  // Shift register: MSB is dropped, shift_in enters at bit 0.
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;

  always_comb begin
    shift_d = {shift_q[WIDTH-2:0], shift_in};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign shift_out = shift_q;

endmodule : reg8_shift8_unit

// File: tb/tb_reg8_shift8_unit.sv
// tb/tb_reg8_shift8_unit.sv - scoreboard bench for reg8_shift8_unit
module tb_reg8_shift8_unit;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] in;
  logic         shift_in;
  logic [W-1:0] out;
  logic [W-1:0] shift_out;

  reg8_shift8_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .shift_in  (shift_in),
    .out       (out),
    .shift_out (shift_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] exp_out;
    logic [W-1:0] exp_sh;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: plain integers, mask keeps it to W bits.
  int unsigned m_out = 0;
  int unsigned m_sh  = 0;
  localparam int unsigned MASK = (1 << W) - 1;

  // Apply inputs away from the edge, then advance the model on the edge
  // and push what the DUT must show afterwards.
  task automatic step(input logic r, input logic [W-1:0] d, input logic s,
                      input string name);
    exp_t e;
    @(negedge clk);
    rst = r; in = d; shift_in = s;
    @(posedge clk);
    if (!r) begin
      m_out = 0;
      m_sh  = 0;
    end else begin
      m_out = d;
      m_sh  = ((m_sh << 1) | s) & MASK;
    end
    e.exp_out = m_out[W-1:0];
    e.exp_sh  = m_sh[W-1:0];
    e.name    = name;
    sb.push_back(e);
  endtask

  // Directed step: also compares the model against hand-derived constants,
  // so a model slip cannot hide behind a matching DUT.
  task automatic step_k(input logic r, input logic [W-1:0] d, input logic s,
                        input logic [W-1:0] k_out, input logic [W-1:0] k_sh,
                        input string name);
    step(r, d, s, name);
    checks++;
    if (m_out[W-1:0] !== k_out || m_sh[W-1:0] !== k_sh) begin
      errors++;
      $display("FAIL %s model out=%h shift=%h required out=%h shift=%h",
               name, m_out[W-1:0], m_sh[W-1:0], k_out, k_sh);
    end
  endtask

  // Monitor: registers update every edge, so every edge with a pending
  // expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (out !== e.exp_out || shift_out !== e.exp_sh) begin
          errors++;
          $display("FAIL %s out=%h shift_out=%h required out=%h shift_out=%h",
                   e.name, out, shift_out, e.exp_out, e.exp_sh);
        end
      end
    end
  end

  initial begin
    logic [7:0] fill;
    int         guard;
    rst = 1'b0; in = '0; shift_in = 1'b0;

    // Reset with inputs driven high.
    step_k(1'b0, 8'hFF, 1'b1, 8'h00, 8'h00, "reset1");
    step_k(1'b0, 8'hFF, 1'b1, 8'h00, 8'h00, "reset2");

    // Parallel loads, one-edge latency.
    step_k(1'b1, 8'b00010111, 1'b0, 8'h17, 8'h00, "load17");
    step_k(1'b1, 8'b10011110, 1'b0, 8'h9E, 8'h00, "load9E");
    step_k(1'b1, 8'b10101100, 1'b0, 8'hAC, 8'h00, "loadAC");
    step_k(1'b1, 8'b01100001, 1'b0, 8'h61, 8'h00, "load61");

    // Reset wins over load.
    step_k(1'b0, 8'b11101000, 1'b0, 8'h00, 8'h00, "rst_noloadE8");
    step_k(1'b0, 8'b10100011, 1'b0, 8'h00, 8'h00, "rst_noloadA3");

    // Shift fill 0,1,1,0,1,0,1,1 -> 6B; after three edges -> 03.
    fill = 8'b01101011;
    for (int i = 7; i >= 0; i--) begin
      if (i == 5)
        step_k(1'b1, 8'h00, fill[i], 8'h00, 8'h03, "fill3");
      else if (i == 0)
        step_k(1'b1, 8'h00, fill[i], 8'h00, 8'h6B, "fill8");
      else
        step(1'b1, 8'h00, fill[i], "fill");
    end

    // Overflow, mid-run reset, resume from zero.
    step_k(1'b1, 8'h00, 1'b0, 8'h00, 8'hD6, "overflowD6");
    step_k(1'b0, 8'h00, 1'b1, 8'h00, 8'h00, "shift_rst");
    step_k(1'b1, 8'h00, 1'b1, 8'h00, 8'h01, "resume01");
    step_k(1'b1, 8'h00, 1'b1, 8'h00, 8'h03, "resume03");

    // Random: in and rst random, shift_in random; model covers both regs.
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 9) != 0), W'($urandom), 1'($urandom), "random");
    end

    // Independence: shift_in held, in toggles wildly; shift_out must follow
    // only the serial stream.
    step(1'b0, 8'h00, 1'b0, "indep_rst");
    for (int i = 0; i < 10; i++) begin
      step(1'b1, W'($urandom), 1'b1, "indep");
    end
    checks++;
    if (m_sh[W-1:0] !== 8'hFF) begin
      errors++;
      $display("FAIL indep_model shift=%h required shift=%h", m_sh[W-1:0], 8'hFF);
    end

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required pending=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_reg8_shift8_unit

// File: doc/reg8_shift8_unit.md
Name: reg8_shift8_unit

Overview:
- Storage block with two independent registers sharing one clock and one reset.
- A WIDTH-bit parallel-load register is built structurally from per-bit flip-flop cells.
- A WIDTH-bit serial-in/parallel-out shift register is described behaviourally.
- Used as basic data-holding and serial-to-parallel staging in the datapath.

Parameters:
- WIDTH, 8: bit width of both the parallel register and the shift register; legal range >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-low; sampled on rising clk edge.
- in  input  WIDTH  parallel data for the parallel register.
- shift_in  input  1  serial data bit for the shift register.
- out  output  WIDTH  parallel register contents.
- shift_out  output  WIDTH  shift register contents.

Behaviour:
- Clocking: single clock domain. Both registers update only on the rising edge of clk. No enables: every edge with rst=1 loads or shifts.
- Reset: synchronous, active-low. On a rising edge with rst=0, out becomes 0 and shift_out becomes 0, regardless of in and shift_in. rst has no effect between edges.
- Parallel register: on a rising edge with rst=1, out <= in.
  - Latency: 1 cycle.
  - Outputs are registered; there is no combinational path from in to out.
- Parallel register structure: out is WIDTH instances of the 1-bit cell, where bit i captures in[i]. Each cell receives clk and rst directly. Its behaviour is bit-exact with a behavioural WIDTH-bit register.
- Shift register: on a rising edge with rst=1, shift_out <= {shift_out[WIDTH-2:0], shift_in}.
  - This is a left shift; the new bit enters at the LSB and the MSB is discarded.
  - After WIDTH edges, the first serial bit sits at bit WIDTH-1 and the last at bit 0.
- Power-up: before the first reset edge, contents are undefined (X in simulation). A bench must apply rst=0 for at least one edge before checking.
- Reset mid-operation: a single edge with rst=0 clears both registers immediately, including a partially filled shift register. Shifting resumes from all-zero on the next edge with rst=1.
- Simultaneous events: rst=0 has priority over load and shift on the same edge.
- Independence: the two registers share no data path. A change on in never affects shift_out, and a change on shift_in never affects out.

Decomposition:
- Shared package holds the WIDTH default constant only; no typedefs are needed.
- One sub-module: dff_bit. It is a 1-bit D flip-flop with ports clk, rst (synchronous active-low, clears to 0), d and q. It is instantiated WIDTH times via generate for the parallel register.
- The shift register stays inline in the top module as a behavioural always block.

Test Plan:
- Reset: drive rst=0 for 2 edges with in=8'hFF and shift_in=1 -> out=8'h00 and shift_out=8'h00 after the first edge.
- Parallel load: with rst=1, drive in=8'b00010111, 8'b10011110, 8'b10101100, 8'b01100001 on successive edges -> out shows each value exactly one edge later: 8'h17, 8'h9E, 8'hAC, 8'h61.
- Load then reset: with out=8'h61, drive rst=0 while in=8'b11101000, then 8'b10100011 -> out=8'h00 on both edges; the new in values are never captured.
- Shift fill: from reset, with rst=1, drive shift_in=0,1,1,0,1,0,1,1 on 8 successive edges -> shift_out=8'b01101011 (8'h6B). The intermediate value after 3 edges is 8'b00000011.
- Shift overflow and reset: continue from 8'h6B with shift_in=0 for one edge -> shift_out=8'hD6. Then apply rst=0 for one edge -> 8'h00. Then drive shift_in=1,1 with rst=1 -> 8'h01, then 8'h03.
- Structural equivalence: random in and rst for 200 cycles -> out matches a behavioural reference register model bit-for-bit every cycle, and shift_out is unaffected by in.
